// File: rtl/gshare_predictor_pkg.sv
// Shared types and constants for the gshare direction predictor.
//   OBQ_ROW_T    : one OBQ row (speculative branch history snapshot)
//   PHT_CTR_T    : 2-bit saturating PHT counter, PHT_WEAK_NT is its reset value
//   OBQ_TW       : OBQ tag width, $clog2(OBQ_SIZE)+1 (extra bit lets tail == depth mean full)
//   pht_sat_update : saturating +/-1 of a counter
// `BH_SIZE / `OBQ_SIZE default here when the surrounding build has not set them.
`ifndef BH_SIZE
`define BH_SIZE 10
`endif
`ifndef OBQ_SIZE
`define OBQ_SIZE 16
`endif

package gshare_predictor_pkg;

    localparam int BH_SIZE  = `BH_SIZE;
    localparam int OBQ_SIZE = `OBQ_SIZE;
    localparam int OBQ_TW   = $clog2(OBQ_SIZE) + 1;

    typedef struct packed {
        logic [BH_SIZE-1:0] branch_history;
    } OBQ_ROW_T;

    typedef logic [1:0] PHT_CTR_T;
    localparam PHT_CTR_T PHT_WEAK_NT = 2'b01;

    function automatic PHT_CTR_T pht_sat_update(input PHT_CTR_T ctr, input logic taken);
        PHT_CTR_T r;
        r = ctr;
        if (taken && (ctr != 2'b11))
            r = ctr + 2'b01;
        else if (!taken && (ctr != 2'b00))
            r = ctr - 2'b01;
        return r;
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Bundle of all non-clock/reset signals of gshare_predictor.
//   master : the predictor (drives predictions and the OBQ control ports)
//   slave  : fetch / OBQ / resolve / retire side
// With GSHARE_PERF_CNT_EN defined the bundle also carries perf_pred_cnt and
// perf_misp_cnt (driven by the predictor).
interface gshare_predictor_if #(
    parameter int BH_BITS = gshare_predictor_pkg::BH_SIZE,
    parameter int TW      = gshare_predictor_pkg::OBQ_TW
);
    // fetch side
    logic                          if_br_valid;
    logic [31:0]                   if_pc;
    logic [TW-1:0]                 obq_tail;
    logic                          pred_valid;
    logic                          pred_taken;
    logic [TW-1:0]                 pred_tag;
    logic                          if_stall;
    logic                          obq_write_en;
    gshare_predictor_pkg::OBQ_ROW_T obq_bh_row;
    // resolve side
    logic                          res_valid;
    logic [31:0]                   res_pc;
    logic                          res_taken;
    logic                          res_mispredict;
    logic [TW-1:0]                 res_tag;
    logic [BH_BITS-1:0]            res_bh;
    logic                          obq_clear_en;
    logic [TW-1:0]                 obq_index;
    // retire side
    logic                          ret_valid;
    logic [TW-1:0]                 ret_tag;
    logic                          obq_shift_en;
    logic [TW-1:0]                 obq_shift_index;
`ifdef GSHARE_PERF_CNT_EN
    logic [31:0]                   perf_pred_cnt;
    logic [31:0]                   perf_misp_cnt;
`endif

    modport master (
        input  if_br_valid, if_pc, obq_tail,
               res_valid, res_pc, res_taken, res_mispredict, res_tag, res_bh,
               ret_valid, ret_tag,
        output pred_valid, pred_taken, pred_tag, if_stall, obq_write_en, obq_bh_row,
               obq_clear_en, obq_index, obq_shift_en, obq_shift_index
`ifdef GSHARE_PERF_CNT_EN
        , output perf_pred_cnt, perf_misp_cnt
`endif
    );

    modport slave (
        output if_br_valid, if_pc, obq_tail,
               res_valid, res_pc, res_taken, res_mispredict, res_tag, res_bh,
               ret_valid, ret_tag,
        input  pred_valid, pred_taken, pred_tag, if_stall, obq_write_en, obq_bh_row,
               obq_clear_en, obq_index, obq_shift_en, obq_shift_index
`ifdef GSHARE_PERF_CNT_EN
        , input perf_pred_cnt, perf_misp_cnt
`endif
    );

endinterface

// File: rtl/gshare_predictor_pht_rmw.sv
// pht_rmw: pattern history table of 2**IDX_BITS 2-bit counters.
//   rd_idx / rd_ctr       : combinational read port used by prediction
//   upd_valid/idx/taken   : training request (one per resolved branch)
// Update pipe: S1 registers index/direction and the counter read; S2 (the
// cycle after) writes the saturated value back. A write is visible on the
// read port two cycles after the request. A request to the index being
// written in the same cycle takes the S2 value instead of the stale array.
module pht_rmw
    import gshare_predictor_pkg::*;
#(
    parameter int IDX_BITS = BH_SIZE
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output PHT_CTR_T            rd_ctr,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
);
    localparam int ENTRIES = 1 << IDX_BITS;

    PHT_CTR_T            pht_q [ENTRIES];
    PHT_CTR_T            pht_d [ENTRIES];

    logic                s1_vld_q,   s1_vld_d;
    logic [IDX_BITS-1:0] s1_idx_q,   s1_idx_d;
    logic                s1_taken_q, s1_taken_d;
    PHT_CTR_T            s1_ctr_q,   s1_ctr_d;

    logic                s2_we;
    logic [IDX_BITS-1:0] s2_idx;
    PHT_CTR_T            s2_ctr;

    always_comb begin
        s2_we  = s1_vld_q;
        s2_idx = s1_idx_q;
        s2_ctr = pht_sat_update(s1_ctr_q, s1_taken_q);

        s1_vld_d   = upd_valid;
        s1_idx_d   = upd_idx;
        s1_taken_d = upd_taken;
        s1_ctr_d   = pht_q[upd_idx];
        // back-to-back hit on the entry being written: forward it
        if (s2_we && (s2_idx == upd_idx))
            s1_ctr_d = s2_ctr;

        pht_d = pht_q;
        if (s2_we)
            pht_d[s2_idx] = s2_ctr;

        rd_ctr = pht_q[rd_idx];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pht_q      <= '{default: PHT_WEAK_NT};
            s1_vld_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_taken_q <= 1'b0;
            s1_ctr_q   <= PHT_WEAK_NT;
        end else begin
            pht_q      <= pht_d;
            s1_vld_q   <= s1_vld_d;
            s1_idx_q   <= s1_idx_d;
            s1_taken_q <= s1_taken_d;
            s1_ctr_q   <= s1_ctr_d;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare conditional-branch direction predictor, sole
// producer of the OBQ.
//   clock, reset : system clock, synchronous active-high reset
//   bus (master) : fetch request/prediction, OBQ push/clear/shift controls,
//                  resolve and retire inputs
// Prediction is combinational: PHT[pc ^ GHR>>1] taken bit, new history row
// pushed into the OBQ, GHR shifted at the clock edge. A mispredict restores
// GHR from the resolved row with its MSB flipped and clears younger OBQ rows.
// Every resolve trains the PHT through pht_rmw.
// Optional: define GSHARE_PERF_CNT_EN to add perf_pred_cnt / perf_misp_cnt.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter  int BH_BITS   = BH_SIZE,
    parameter  int OBQ_DEPTH = OBQ_SIZE,
    localparam int TW        = $clog2(OBQ_DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    gshare_predictor_if.master bus
);
    logic [BH_BITS-1:0] ghr_q, ghr_d;
    logic [BH_BITS-1:0] pred_idx, upd_idx, new_hist;
    PHT_CTR_T           pred_ctr;
    logic               pred_t, full, kill, fire;
    logic               unused_bits;

    // LSB of the history is dropped from the hash so that resolve can
    // rebuild the index from the pushed row (which has shifted it out).
    always_comb begin
        full     = (bus.obq_tail == TW'(OBQ_DEPTH));
        kill     = bus.res_valid & bus.res_mispredict;
        pred_idx = bus.if_pc[BH_BITS+1:2] ^ {1'b0, ghr_q[BH_BITS-1:1]};
        upd_idx  = bus.res_pc[BH_BITS+1:2] ^ {1'b0, bus.res_bh[BH_BITS-2:0]};
        pred_t   = pred_ctr[1];
        new_hist = {pred_t, ghr_q[BH_BITS-1:1]};
        fire     = bus.if_br_valid & ~full & ~kill & ~reset;

        ghr_d = ghr_q;
        if (kill)
            ghr_d = {~bus.res_bh[BH_BITS-1], bus.res_bh[BH_BITS-2:0]};
        else if (fire)
            ghr_d = new_hist;
    end

    assign unused_bits = ^{bus.if_pc[31:BH_BITS+2], bus.if_pc[1:0],
                           bus.res_pc[31:BH_BITS+2], bus.res_pc[1:0], ghr_q[0]};

    always_ff @(posedge clock) begin
        if (reset)
            ghr_q <= '0;
        else
            ghr_q <= ghr_d;
    end

    pht_rmw #(.IDX_BITS(BH_BITS)) u_pht (
        .clock     (clock),
        .reset     (reset),
        .rd_idx    (pred_idx),
        .rd_ctr    (pred_ctr),
        .upd_valid (bus.res_valid),
        .upd_idx   (upd_idx),
        .upd_taken (bus.res_taken)
    );

    // All outputs are forced low while reset is held.
    always_comb begin
        bus.pred_valid      = 1'b0;
        bus.pred_taken      = 1'b0;
        bus.pred_tag        = '0;
        bus.if_stall        = 1'b0;
        bus.obq_write_en    = 1'b0;
        bus.obq_bh_row      = '0;
        bus.obq_clear_en    = 1'b0;
        bus.obq_index       = '0;
        bus.obq_shift_en    = 1'b0;
        bus.obq_shift_index = '0;
        if (!reset) begin
            bus.pred_valid                = fire;
            bus.pred_taken                = pred_t;
            bus.pred_tag                  = bus.obq_tail;
            bus.if_stall                  = bus.if_br_valid & full & ~kill;
            bus.obq_write_en              = fire;
            bus.obq_bh_row.branch_history = new_hist;
            bus.obq_clear_en              = kill;
            bus.obq_index                 = bus.res_tag + TW'(1);
            bus.obq_shift_en              = bus.ret_valid;
            bus.obq_shift_index           = bus.ret_tag;
        end
    end

`ifdef GSHARE_PERF_CNT_EN
    logic [31:0] perf_pred_cnt_q, perf_pred_cnt_d;
    logic [31:0] perf_misp_cnt_q, perf_misp_cnt_d;

    always_comb begin
        perf_pred_cnt_d = perf_pred_cnt_q + {31'd0, fire};
        perf_misp_cnt_d = perf_misp_cnt_q + {31'd0, kill};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_pred_cnt_q <= '0;
            perf_misp_cnt_q <= '0;
        end else begin
            perf_pred_cnt_q <= perf_pred_cnt_d;
            perf_misp_cnt_q <= perf_misp_cnt_d;
        end
    end

    assign bus.perf_pred_cnt = perf_pred_cnt_q;
    assign bus.perf_misp_cnt = perf_misp_cnt_q;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor (BH_BITS=10, OBQ_DEPTH=16, TW=5).
// Inputs change 1 time unit after the rising edge; outputs are checked
// mid-cycle. GHR is observed through obq_bh_row = {taken, GHR[9:1]}.
module tb_gshare_predictor;
    import gshare_predictor_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_pred = 0;
    int   exp_misp = 0;

    always #5 clock = ~clock;

    gshare_predictor_if bus ();

    gshare_predictor dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic idle();
        bus.if_br_valid    = 1'b0;
        bus.res_valid      = 1'b0;
        bus.res_mispredict = 1'b0;
        bus.res_taken      = 1'b0;
        bus.ret_valid      = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic misp,
                           input logic [4:0] tag, input logic [9:0] bh);
        bus.res_valid      = 1'b1;
        bus.res_pc         = pc;
        bus.res_taken      = tk;
        bus.res_mispredict = misp;
        bus.res_tag        = tag;
        bus.res_bh         = bh;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [4:0] tail);
        bus.if_br_valid = 1'b1;
        bus.if_pc       = pc;
        bus.obq_tail    = tail;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset: everything gated low even with active inputs
        reset = 1'b1;
        idle();
        bus.if_pc = 32'h0; bus.obq_tail = '0; bus.res_pc = '0; bus.res_tag = '0;
        bus.res_bh = '0; bus.ret_tag = '0;
        fetch(32'h40, 5'd3);
        bus.ret_valid = 1'b1; bus.ret_tag = 5'd3; bus.res_tag = 5'd7;
        tick(); tick(); mid();
        chk("rst_pred_valid", bus.pred_valid, 0);
        chk("rst_write_en", bus.obq_write_en, 0);
        chk("rst_obq_index", bus.obq_index, 0);
        chk("rst_shift_en", bus.obq_shift_en, 0);
        chk("rst_pred_tag", bus.pred_tag, 0);

        tick(); reset = 1'b0; idle(); bus.res_tag = '0; bus.obq_tail = '0;
        bus.if_pc = 32'h40; mid();
        chk("rst_taken_40", bus.pred_taken, 0);
        chk("rst_ghr_row", bus.obq_bh_row.branch_history, 0);
        tick(); bus.if_pc = 32'hFFC; mid();
        chk("rst_taken_ffc", bus.pred_taken, 0);

        // ---- training at idx 0x10, visibility latency
        tick(); bus.if_pc = 32'h40; resolve(32'h40, 1'b1, 1'b0, 5'd0, 10'd0); mid();
        chk("lat_c0", bus.pred_taken, 0);
        tick(); mid();
        chk("lat_c1", bus.pred_taken, 0);
        tick(); idle(); mid();
        chk("lat_c2", bus.pred_taken, 1);
        tick(); fetch(32'h40, 5'd0); mid();
        chk("train_taken", bus.pred_taken, 1);
        chk("train_valid", bus.pred_valid, 1);
        chk("train_row", bus.obq_bh_row.branch_history, 10'h200);

        // ---- reset mid-operation: in-flight update to idx 0x20 discarded
        tick(); idle(); resolve(32'h80, 1'b1, 1'b0, 5'd0, 10'd0);
        tick(); idle(); reset = 1'b1;
        tick(); reset = 1'b0; bus.if_pc = 32'h80; mid();
        chk("rstmid_80", bus.pred_taken, 0);
        tick(); bus.if_pc = 32'h40; mid();
        chk("rstmid_40", bus.pred_taken, 0);
        chk("rstmid_ghr", bus.obq_bh_row.branch_history, 0);

        // ---- five fetches, tags 0..4
        for (int k = 0; k < 5; k++) begin
            tick(); fetch(32'h100 + 32'(4 * k), 5'(k)); mid();
            chk("fetch_tag", bus.pred_tag, k);
            chk("fetch_valid", bus.obq_write_en, 1);
            exp_pred++;
        end

        // ---- mispredict tag 2
        tick(); idle(); resolve(32'h108, 1'b1, 1'b1, 5'd2, 10'b1000000001); mid();
        chk("misp_clear", bus.obq_clear_en, 1);
        chk("misp_index", bus.obq_index, 3);
        exp_misp++;
        tick(); idle(); fetch(32'h200, 5'd3); mid();
        chk("misp_ghr_row", bus.obq_bh_row.branch_history, 0);
        chk("misp_clear_off", bus.obq_clear_en, 0);
        exp_pred++;
        // GHR restored to 10'b1101100110
        tick(); idle(); resolve(32'h108, 1'b0, 1'b1, 5'd3, 10'b0101100110); mid();
        chk("misp2_index", bus.obq_index, 4);
        exp_misp++;
        tick(); idle(); fetch(32'h200, 5'd4); mid();
        chk("misp2_ghr_row", bus.obq_bh_row.branch_history, 10'h1B3);
        exp_pred++;

        // ---- OBQ full: stall, GHR (0x1B3) held
        tick(); fetch(32'h200, 5'(OBQ_SIZE)); mid();
        chk("full_stall", bus.if_stall, 1);
        chk("full_write_en", bus.obq_write_en, 0);
        chk("full_pred_valid", bus.pred_valid, 0);
        tick(); fetch(32'h200, 5'd5); mid();
        chk("full_ghr_held", bus.obq_bh_row.branch_history, 10'h0D9);
        chk("full_stall_off", bus.if_stall, 0);
        exp_pred++;

        // ---- kill + fetch + retire in one cycle
        tick(); fetch(32'h200, 5'd6); resolve(32'h500, 1'b1, 1'b1, 5'd3, 10'd0);
        bus.ret_valid = 1'b1; bus.ret_tag = 5'd0; mid();
        chk("kfr_write_en", bus.obq_write_en, 0);
        chk("kfr_stall", bus.if_stall, 0);
        chk("kfr_clear", bus.obq_clear_en, 1);
        chk("kfr_shift_en", bus.obq_shift_en, 1);
        chk("kfr_shift_idx", bus.obq_shift_index, 0);
        exp_misp++;
        tick(); idle(); bus.ret_valid = 1'b1; bus.ret_tag = 5'd5; mid();
        chk("ret_shift_idx", bus.obq_shift_index, 5);
        chk("ret_clear_off", bus.obq_clear_en, 0);
`ifdef GSHARE_PERF_CNT_EN
        chk("perf_pred", bus.perf_pred_cnt, 32'(exp_pred));
        chk("perf_misp", bus.perf_misp_cnt, 32'(exp_misp));
`endif

        // ---- saturation and back-to-back forwarding at idx 0xC0
        tick(); idle(); reset = 1'b1;
        tick(); reset = 1'b0; bus.if_pc = 32'h300;
        for (int k = 0; k < 3; k++) begin
            tick(); resolve(32'h300, 1'b1, 1'b0, 5'd0, 10'd0);
        end
        tick(); resolve(32'h300, 1'b0, 1'b0, 5'd0, 10'd0);
        tick(); resolve(32'h300, 1'b0, 1'b0, 5'd0, 10'd0); mid();
        chk("sat_hi_taken", bus.pred_taken, 1);
        tick(); idle(); mid();
        tick(); resolve(32'h300, 1'b0, 1'b0, 5'd0, 10'd0); mid();
        chk("fwd_nt_ctr1", bus.pred_taken, 0);
        tick(); resolve(32'h300, 1'b0, 1'b0, 5'd0, 10'd0);
        tick(); idle();
        tick(); mid();
        chk("sat_lo_taken", bus.pred_taken, 0);
`ifdef GSHARE_PERF_CNT_EN
        chk("perf_pred_rst", bus.perf_pred_cnt, 0);
        chk("perf_misp_rst", bus.perf_misp_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
